bcd_seq_converter: RTL

Iterative shift-and-add-3 (double-dabble) binary-to-BCD converter with valid/ready handshakes on both sides. It converts an unsigned binary word into packed BCD digits over `WIDTH` clock cycles. It sits between the switch/binary input path and the 7-segment display multiplexer. It also holds the last completed result on `out_bcd` so the multiplexer can read digits continuously.

---
 rtl/bcd_seq_converter_pkg.sv | 27 ++
 rtl/bcd_seq_converter_digit_adjust.sv | 19 +
 rtl/bcd_seq_converter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcd_seq_converter_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
  function automatic bit digits_fit(input int width, input int digits);
    longint pow10;
    longint max_bin;
    pow10   = 64'sd1;
    for (int i = 0; i < digits; i++) begin
      pow10 = pow10 * 64'sd10;
    end
    max_bin = (64'sd1 <<< width) - 64'sd1;
    return (pow10 > max_bin);
  endfunction

endpackage

// File: rtl/bcd_seq_converter_digit_adjust.sv
// One double-dabble correction cell: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  // Add-3 correction, result truncated to one digit.
  always_comb begin
    if (d >= DIGIT_W'(ADJ_THRESH)) begin
      q = d + DIGIT_W'(ADJ_ADD);
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative shift-and-add-3 binary-to-BCD converter with valid/ready on both
// sides. One input bit is consumed per cycle; the last finished result stays
// on out_bcd so a display multiplexer can read it continuously.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                      busy
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Refuse to build a converter whose digit count cannot hold the largest input.
  if (!digits_fit(WIDTH, DIGITS)) begin : g_width_check
    $error("bcd_seq_converter: DIGITS too small for WIDTH");
  end

  state_e             state_r;
  state_e             state_s;
  logic [WIDTH-1:0]   bin_r;
  logic [WIDTH-1:0]   bin_s;
  logic [BCD_W-1:0]   work_r;
  logic [BCD_W-1:0]   work_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [BCD_W-1:0]   out_bcd_r;
  logic [BCD_W-1:0]   out_bcd_s;
  logic               out_valid_r;
  logic               out_valid_s;
  logic               in_ready_r;
  logic               in_ready_s;
  logic               busy_r;
  logic               busy_s;

  logic [BCD_W-1:0]   adj_s;
  logic [BCD_W-1:0]   work_shift_s;

  // One correction cell per digit of the working register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .d (work_r[g*DIGIT_W +: DIGIT_W]),
      .q (adj_s [g*DIGIT_W +: DIGIT_W])
    );
  end

  // Corrected digits shifted left, with the next binary bit entering at the bottom.
  always_comb begin
    work_shift_s = {adj_s[BCD_W-2:0], bin_r[WIDTH-1]};
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_s     = state_r;
    bin_s       = bin_r;
    work_s      = work_r;
    cnt_s       = cnt_r;
    out_bcd_s   = out_bcd_r;
    out_valid_s = out_valid_r;

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          bin_s   = in_bin;
          work_s  = '0;
          cnt_s   = CNT_W'(WIDTH);
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
        work_s = work_shift_s;
        bin_s  = {bin_r[WIDTH-2:0], 1'b0};
        cnt_s  = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          out_bcd_s   = work_shift_s;
          out_valid_s = 1'b1;
          state_s     = DONE;
        end else begin
          state_s = SHIFT;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        out_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they match the state register.
    in_ready_s = (state_s == IDLE);
    busy_s     = (state_s == SHIFT) || (state_s == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bin_r       <= '0;
      work_r      <= '0;
      cnt_r       <= '0;
      out_bcd_r   <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      bin_r       <= bin_s;
      work_r      <= work_s;
      cnt_r       <= cnt_s;
      out_bcd_r   <= out_bcd_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_bcd   = out_bcd_r;

endmodule
